// File: rtl/rcu_clkdiv_pkg.sv
// Shared state encoding and width constant for the rcu_clkdiv divider bank.
package rcu_clkdiv_pkg;

  typedef enum logic [1:0] {IDLE, RUN, STOP} clkdiv_state_e;

  // Default ratio-field width; the period counter never needs more bits than the ratio.
  localparam int CNT_W = 8;

endpackage

// File: rtl/rcu_clkdiv_ch.sv
// One divider channel: run/stop FSM, period counter, ratio applied only at period boundaries.
// Strobe and square wave are decoded from flops; RCU_CLKDIV_SYNC_EN adds the sync_i phase-align input.
module rcu_clkdiv_ch
  import rcu_clkdiv_pkg::*;
#(
  parameter int DIV_WIDTH = CNT_W,
  parameter int DIV_RST   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_we_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  input  logic                 ch_en_i,
`ifdef RCU_CLKDIV_SYNC_EN
  input  logic                 sync_i,
`endif
  output logic                 en_o,
  output logic                 div_o,
  output logic                 run_o,
  output logic                 pend_o
);

  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

  clkdiv_state_e        state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] act_q, act_d;
  logic [DIV_WIDTH-1:0] nxt_q, nxt_d;
  logic                 pend_q, pend_d;
  logic                 div_q, div_d;
  logic [DIV_WIDTH-1:0] reff, reff_nxt;
  logic                 active, wrap, bound;

  always_comb begin
    reff   = (act_q == '0) ? ONE : act_q;
    active = (state_q != IDLE);
    wrap   = active && (cnt_q == reff - ONE);
  end

`ifdef RCU_CLKDIV_SYNC_EN
  logic sync_hit, sup_q, sup_d;

  // The strobe is masked in the first post-sync cycle so it stays register-decoded.
  always_comb begin
    sync_hit = sync_i && active;
    bound    = wrap || sync_hit;
    sup_d    = sync_hit;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sup_q <= 1'b0;
    else       sup_q <= sup_d;
  end

  assign en_o = wrap && !sup_q;
`else
  assign bound = wrap;
  assign en_o  = wrap;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    nxt_d   = nxt_q;
    pend_d  = pend_q;
    unique case (state_q)
      IDLE: if (ch_en_i) begin
        state_d = RUN;
        cnt_d   = '0;
      end
      RUN:  if (!ch_en_i) state_d = wrap ? IDLE : STOP;
      STOP: if (ch_en_i) state_d = RUN;
            else if (wrap) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (active) cnt_d = wrap ? '0 : cnt_q + ONE;
`ifdef RCU_CLKDIV_SYNC_EN
    if (sync_hit) begin
      cnt_d   = '0;
      state_d = (state_q == RUN && ch_en_i) ? RUN : IDLE;
    end
`endif
    // pend_q is the pre-edge flag, so a write landing on a wrap waits for the next one.
    if (pend_q && (!active || bound)) begin
      act_d  = nxt_q;
      pend_d = 1'b0;
    end
    if (cfg_we_i) begin
      nxt_d  = cfg_div_i;
      pend_d = 1'b1;
    end
    reff_nxt = (act_d == '0) ? ONE : act_d;
    div_d    = (state_d != IDLE) && (cnt_d < (reff_nxt >> 1));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      act_q   <= DIV_WIDTH'(DIV_RST);
      nxt_q   <= DIV_WIDTH'(DIV_RST);
      pend_q  <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      nxt_q   <= nxt_d;
      pend_q  <= pend_d;
      div_q   <= div_d;
    end
  end

  assign run_o  = active;
  assign pend_o = pend_q;
  assign div_o  = div_q;

endmodule

// File: rtl/rcu_clkdiv_bank.sv
// Bank of NCH independent clock dividers sharing one ratio write port; out-of-range channel writes drop.
// Outputs are per-channel and register-decoded; RCU_CLKDIV_SYNC_EN adds a bank-wide sync_i input.
module rcu_clkdiv_bank
  import rcu_clkdiv_pkg::*;
#(
  parameter  int NCH       = 4,
  parameter  int DIV_WIDTH = CNT_W,
  parameter  int DIV_RST   = 2,
  localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_we_i,
  input  logic [CH_W-1:0]      cfg_ch_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  input  logic [NCH-1:0]       ch_en_i,
`ifdef RCU_CLKDIV_SYNC_EN
  input  logic                 sync_i,
`endif
  output logic [NCH-1:0]       en_o,
  output logic [NCH-1:0]       div_o,
  output logic [NCH-1:0]       run_o,
  output logic [NCH-1:0]       pend_o
);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic ch_we;
    assign ch_we = cfg_we_i && (cfg_ch_i == CH_W'(c));

    rcu_clkdiv_ch #(
      .DIV_WIDTH (DIV_WIDTH),
      .DIV_RST   (DIV_RST)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .cfg_we_i  (ch_we),
      .cfg_div_i (cfg_div_i),
      .ch_en_i   (ch_en_i[c]),
`ifdef RCU_CLKDIV_SYNC_EN
      .sync_i    (sync_i),
`endif
      .en_o      (en_o[c]),
      .div_o     (div_o[c]),
      .run_o     (run_o[c]),
      .pend_o    (pend_o[c])
    );
  end

endmodule

// File: doc/rcu_clkdiv_bank.md
Name: rcu_clkdiv_bank

Overview:
- Parametrised bank of NCH independent programmable clock dividers for the next-generation RCU.
- Runs entirely in the core clock domain. Each channel produces a one-cycle clock-enable strobe and a registered divided square wave.
- Ratio changes and channel stops take effect only at period boundaries, so downstream logic never sees a truncated period.
- Configured through a simple write port driven by the RCU APB4 register file.

Parameters:
- NCH, 4, number of divider channels (1..16).
- DIV_WIDTH, 8, width of the divide-ratio field.
- DIV_RST, 2, reset ratio for every channel.

Ports:
- clk_i  input  1  core clock
- rst_i  input  1  asynchronous reset, active-high
- cfg_we_i  input  1  ratio write strobe
- cfg_ch_i  input  $clog2(NCH) (min 1)  target channel of write
- cfg_div_i  input  DIV_WIDTH  new ratio R
- ch_en_i  input  NCH  per-channel run request (level)
- en_o  output  NCH  one-cycle enable strobe, once per period
- div_o  output  NCH  divided square wave
- run_o  output  NCH  channel in RUN or STOP state
- pend_o  output  NCH  ratio write accepted, not yet applied

Behaviour:
- Reset: all outputs 0; all FSMs IDLE; cnt=0; active ratio and pending ratio = DIV_RST; pend flag 0.
- Interface decision: one clock (clk_i); reset rst_i is asynchronous and active-high.
- Per-channel FSM with states IDLE, RUN, STOP.
  - IDLE -> RUN when ch_en_i=1. cnt is loaded with 0 on entry.
  - RUN -> STOP when ch_en_i=0 and no wrap occurs in this cycle.
  - RUN -> IDLE directly when ch_en_i=0 in a wrap cycle.
  - STOP -> IDLE at the next wrap.
  - STOP -> RUN when ch_en_i returns to 1 before the wrap; cnt is not reset.
- Counter:
  - cnt counts 0..Reff-1, where Reff = max(R,1).
  - Wrap happens in the cycle where cnt==Reff-1 while in RUN or STOP.
  - On wrap, cnt <= 0.
- en_o[c] = (RUN|STOP) && cnt==Reff-1. It is decoded from registers only; there is no combinational path from any input.
  - First strobe comes R cycles after the first RUN cycle.
  - R=0 or 1: strobe every cycle.
- div_o[c]:
  - Registered; in RUN/STOP it is 1 while cnt < Reff/2 (integer division), else 0.
  - Odd R: high for floor(R/2) cycles.
  - R<=1: div_o is constant 0.
  - IDLE: div_o is 0.
- Ratio update:
  - cfg_we_i latches cfg_div_i into the pending register of channel cfg_ch_i and sets pend.
  - Channel in IDLE: the value is applied on the next edge and pend clears with it; pend_o pulses for one cycle.
  - Channel in RUN/STOP: the value is applied at the next wrap, and pend clears at that wrap.
  - A second write before apply overwrites the pending value (last write wins).
  - A write in the same cycle as a wrap is not applied at that wrap; the old ratio is used for the wrap and the new value is applied at the following wrap.
  - cfg_ch_i >= NCH: write ignored.
- run_o = state != IDLE.
- Asynchronous rst_i mid-period returns everything to reset values immediately. No strobe is generated on reset release until ch_en_i is seen high.

Optional Feature:
- Macro: RCU_CLKDIV_SYNC_EN.
- With the macro: an extra port sync_i (input, 1 bit).
  - A pulse forces cnt=0 on every RUN/STOP channel on the next edge, phase-aligning them; en_o is suppressed that cycle.
  - Pending ratios are applied at the sync as if it were a wrap.
  - STOP channels go to IDLE.
- Without the macro: no sync_i port and no related logic.

Decomposition:
- Package rcu_clkdiv_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, STOP} clkdiv_state_e;
  - the CNT_W helper constant.
- One sub-module, rcu_clkdiv_ch: a single channel (FSM, counter, pending register, output decode) with DIV_WIDTH/DIV_RST parameters. The bank instantiates it NCH times with a generate loop and decodes cfg_ch_i to a per-channel write strobe.

Test Plan:
- Reset default: R=2, ch_en[0]=1 -> en_o[0] strobes at cycles 2, 4, 6 after RUN entry; div_o[0] = 1,0,1,0...; run_o[0]=1.
- Odd ratio: write R=5 to ch1 while IDLE, then enable -> pend_o[1] pulses for one cycle; en_o[1] strobes every 5 cycles; div_o[1] high 2 cycles, low 3 cycles.
- Boundary update: ch0 running with R=4; write R=3 at cnt=1 -> the current period completes with 4 cycles; the next period has 3 cycles; pend_o[0] clears at the wrap.
- Write at wrap plus overwrite:
  - Write R=6 exactly in the wrap cycle -> the old ratio runs one more full period, then R=6 applies.
  - Two writes (7 then 9) before a wrap -> 9 applies.
- Graceful stop: drop ch_en mid-period at cnt=1 with R=8 -> STOP; the final strobe occurs at cnt=7, then IDLE and run_o=0. Re-raising ch_en during STOP -> RUN with no phase reset.
- Async reset mid-run, plus sync (with RCU_CLKDIV_SYNC_EN):
  - Assert rst_i between edges -> all outputs 0 immediately.
  - With the macro defined, sync_i pulse on ch0 (R=4) and ch1 (R=6) -> both cnt=0 on the next edge and both first strobes are aligned to that edge.
